rsa_result_framer: RTL and testbench

//  Downstream stage of the modular-exponentiation datapath. Accepts one WIDTH-bit RSA result
//  (ciphertext/plaintext) per valid/ready handshake and serialises it as a framed byte stream
//  for the Flipper-side byte transmitter: SYNC byte, WIDTH/8 data bytes MSB-first, XOR checksum.

---
 rtl/rsa_result_framer.sv | 121 ++++++++++++
 tb/tb_rsa_result_framer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_result_framer.sv
// rsa_result_framer: serialises one WIDTH-bit result word into a byte frame
// (SYNC, WIDTH/8 data bytes MSB-first, XOR checksum of the data bytes).
// Every output is a flop. Each output's next value is derived from the next
// state, so the outputs line up with the state register.
module rsa_result_framer #(
    parameter int          WIDTH     = 128,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int BYTES = WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [7:0]       csum_q, csum_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic       in_ready_q, in_ready_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic cap, xfer;

    // in_ready_q is high exactly in IDLE and tx_valid_q exactly outside it
    assign cap  = in_valid & in_ready_q;
    assign xfer = tx_valid_q & tx_ready;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus shift/checksum/counter updates; all hold while stalled
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cap) begin
                shift_d = in_result;
                csum_d  = '0;
                cnt_d   = '0;
                state_d = HDR;
            end
            HDR:  if (xfer) state_d = DATA;
            DATA: if (xfer) begin
                shift_d = shift_q << 8;
                csum_d  = csum_q ^ shift_q[WIDTH-1 -: 8];
                if (cnt_q == LAST_CNT) state_d = CSUM;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            CSUM: if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values, taken from where the FSM is heading
    always_comb begin
        in_ready_d   = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        tx_valid_d   = (state_d != IDLE);
        frame_done_d = (state_q == CSUM) && xfer;
        case (state_d)
            HDR:     tx_data_d = SYNC_BYTE;
            DATA:    tx_data_d = shift_d[WIDTH-1 -: 8];
            CSUM:    tx_data_d = csum_d;
            default: tx_data_d = 8'h00;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            in_ready_q   <= in_ready_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rsa_result_framer.sv
// Bench for rsa_result_framer: table of directed frames, hand-written
// reset-abort and back-to-back sequences, then random words with random
// transmitter backpressure checked against a byte-level frame model.
module tb_rsa_result_framer;

    localparam int W = 128;
    localparam int NB = W / 8;
    localparam int FL = NB + 2;

    logic         clk, rst;
    logic [W-1:0] in_result;
    logic         in_valid, in_ready;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_ready, busy, frame_done;

    rsa_result_framer #(.WIDTH(W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_result(in_result), .in_valid(in_valid),
        .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    logic [7:0] expq[$];
    int fd_cnt = 0;
    int fd_err = 0;
    int stab_err = 0;

    // Transfer monitor: logs bytes, checks stall stability and frame_done timing
    initial begin
        logic prev_stall, prev_last;
        logic [7:0] prev_data;
        prev_stall = 0; prev_last = 0; prev_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_last = 0;
            end else begin
                if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
                if (frame_done) begin
                    fd_cnt++;
                    if (!prev_last || !in_ready || busy) fd_err++;
                end else if (prev_last) fd_err++;
                prev_last = 0;
                if (tx_valid && tx_ready) begin
                    got.push_back(tx_data);
                    prev_last = (got.size() % FL == 0);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_csum(input logic [W-1:0] w);
        logic [7:0] c = 0;
        for (int i = 0; i < NB; i++) c ^= w[8*i +: 8];
        return c;
    endfunction

    task automatic add_exp(input logic [W-1:0] w, input logic [7:0] cs);
        expq.push_back(8'hA5);
        for (int i = 0; i < NB; i++) expq.push_back(w[W-1-8*i -: 8]);
        expq.push_back(cs);
    endtask

    task automatic cmp_frames(input string nm);
        chk({nm, " nbytes"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s byte%0d", nm, i), (i < got.size()) ? got[i] : ~expq[i], expq[i]);
        chk({nm, " stable"}, stab_err, 0);
        chk({nm, " fdtiming"}, fd_err, 0);
    endtask

    // One frame: capture w, optional stall window / random ready / in_valid pulse
    task automatic run_frame(input string nm, input logic [W-1:0] w, input int stall_at,
                             input int stall_len, input bit rnd_rdy, input int pulse_at,
                             input logic [7:0] cs);
        int cyc = 0;
        int left = stall_len;
        bit pulsed = 0;
        got.delete(); expq.delete(); fd_cnt = 0;
        while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk({nm, " idle"}, in_ready, 1);
        in_result = w; in_valid = 1; tx_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; in_result = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        while (fd_cnt == 0 && cyc < 400) begin
            if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
            else if (got.size() == stall_at && left > 0) begin tx_ready = 0; left--; end
            else tx_ready = 1;
            if (got.size() == pulse_at && !pulsed) begin
                pulsed = 1; in_valid = 1;
                chk({nm, " rdy_busy"}, in_ready, 0);
            end else in_valid = 0;
            @(posedge clk); #1; cyc++;
        end
        in_valid = 0; tx_ready = 1;
        chk({nm, " timeout"}, cyc < 400, 1);
        chk({nm, " fdcount"}, fd_cnt, 1);
        add_exp(w, cs);
        cmp_frames(nm);
        repeat (3) @(posedge clk);
        #1 chk({nm, " idle_after"}, busy, 0);
    endtask

    typedef struct {
        logic [W-1:0] word;
        int           stall_at;
        int           stall_len;
        int           pulse_at;
        logic [7:0]   csum;
    } vec_t;

    vec_t vt[6];
    int cyc;
    logic [W-1:0] w0, w1;

    initial begin
        vt[0] = '{128'h1, -1, 0, -1, 8'h01};
        vt[1] = '{128'h0123456789ABCDEF_FEDCBA9876543210, -1, 0, -1, 8'h00};
        vt[2] = '{128'h1, 4, 5, -1, 8'h01};
        vt[3] = '{128'h0011223344556677_8899AABBCCDDEEFF, -1, 0, 6, 8'h00};
        vt[4] = '{128'h80, 0, 3, -1, 8'h80};
        vt[5] = '{128'h0F000000_00000000_00000000_000000F0, 17, 4, 9, 8'hFF};

        rst = 1; in_valid = 0; tx_ready = 0; in_result = '0;
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 0;

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("vec%0d", i), vt[i].word, vt[i].stall_at,
                      vt[i].stall_len, 0, vt[i].pulse_at, vt[i].csum);

        // Reset in the middle of the data bytes, then a fresh frame
        got.delete(); in_result = {4{32'h13579BDF}}; in_valid = 1; tx_ready = 1;
        @(posedge clk); #1 in_valid = 0;
        cyc = 0;
        while (got.size() < 8 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("abort reach", got.size(), 8);
        rst = 1; #1;
        chk("abort tx_valid", tx_valid, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        @(posedge clk); #1 rst = 0;
        run_frame("after_rst", {W{1'b1}}, -1, 0, 0, -1, 8'h00);

        // in_valid held across two words: second captured only after first frame
        w0 = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF;
        w1 = 128'h55AA55AA_00FF00FF_DEAD0001_76543210;
        got.delete(); expq.delete(); fd_cnt = 0;
        in_result = w0; in_valid = 1; tx_ready = 1;
        @(posedge clk); #1 in_result = w1;
        cyc = 0;
        while (fd_cnt < 1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        in_valid = 0;
        chk("b2b busy", busy, 1);
        while (fd_cnt < 2 && cyc < 400) begin @(posedge clk); #1; cyc++; end
        chk("b2b timeout", cyc < 400, 1);
        add_exp(w0, model_csum(w0));
        add_exp(w1, model_csum(w1));
        cmp_frames("b2b");
        repeat (3) @(posedge clk);

        // Random words and random transmitter readiness against the model
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] rw;
            rw = {$urandom, $urandom, $urandom, $urandom};
            run_frame($sformatf("rnd%0d", i), rw, -1, 0, 1, $urandom_range(1, 16), model_csum(rw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
